// File: rtl/sbus_arbiter.sv
// Round-robin arbiter and sequencer for the 8-bit SB_SPI system bus.
// One transaction at a time; sb_stb is held until sb_ack or until the
// timeout watchdog expires. Every output is registered.
//
// state | meaning
// IDLE  | waiting for any req_stb; grants the round-robin winner
// XFER  | sb_stb asserted, waiting for sb_ack or timeout
// DONE  | done/err pulse cycle, counter cleared
module sbus_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_stb,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [8*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     req_done,
  output logic [NREQ-1:0]     req_err,
  output logic [7:0]          req_rdata,
  output logic [1:0]          grant_id,
  output logic                busy,
  output logic                sb_stb,
  output logic                sb_rw,
  output logic [7:0]          sb_addr,
  output logic [7:0]          sb_wdata,
  input  logic [7:0]          sb_rdata,
  input  logic                sb_ack
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      ptr, ptr_nxt;

  logic            stb_nxt, rw_nxt, busy_nxt;
  logic [7:0]      addr_nxt, wdata_nxt, rdata_nxt;
  logic [1:0]      gid_nxt;
  logic [NREQ-1:0] done_nxt, err_nxt, gsel;

  logic            found;
  logic [1:0]      win, win_next;
  logic [2:0]      rr_sum, win_sum;
  logic            win_rw;
  logic [7:0]      win_addr, win_wdata;

  // Round-robin search from ptr, plus mux of the winner's request fields.
  always_comb begin
    found     = 1'b0;
    win       = 2'd0;
    rr_sum    = 3'd0;
    win_rw    = 1'b0;
    win_addr  = 8'h00;
    win_wdata = 8'h00;
    gsel      = '0;
    for (int i = 0; i < NREQ; i++) begin
      rr_sum = {1'b0, ptr} + 3'(i);
      if (rr_sum >= 3'(NREQ)) rr_sum = rr_sum - 3'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!found && rr_sum == 3'(j) && req_stb[j]) begin
          found = 1'b1;
          win   = 2'(j);
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (win == 2'(j)) begin
        win_rw    = req_rw[j];
        win_addr  = req_addr[8*j +: 8];
        win_wdata = req_wdata[8*j +: 8];
      end
      gsel[j] = (grant_id == 2'(j));
    end
    win_sum  = {1'b0, win} + 3'd1;
    win_next = (win_sum == 3'(NREQ)) ? 2'd0 : win_sum[1:0];
  end

  // Next-state and next-output logic; outputs hold unless a transition changes them.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    stb_nxt   = sb_stb;
    rw_nxt    = sb_rw;
    addr_nxt  = sb_addr;
    wdata_nxt = sb_wdata;
    rdata_nxt = req_rdata;
    gid_nxt   = grant_id;
    done_nxt  = '0;
    err_nxt   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = XFER;
          stb_nxt   = 1'b1;
          rw_nxt    = win_rw;
          addr_nxt  = win_addr;
          wdata_nxt = win_wdata;
          gid_nxt   = win;
          ptr_nxt   = win_next;
          cnt_nxt   = '0;
        end
      end
      XFER: begin
        if (sb_ack) begin
          // ack takes priority over a coincident timeout
          stb_nxt   = 1'b0;
          done_nxt  = gsel;
          if (!sb_rw) rdata_nxt = sb_rdata;
          state_nxt = DONE;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
          stb_nxt   = 1'b0;
          done_nxt  = gsel;
          err_nxt   = gsel;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == XFER) || (state_nxt == DONE);
  end

  // State, counter, pointer and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= 2'd0;
      sb_stb    <= 1'b0;
      sb_rw     <= 1'b0;
      sb_addr   <= 8'h00;
      sb_wdata  <= 8'h00;
      req_rdata <= 8'h00;
      grant_id  <= 2'd0;
      req_done  <= '0;
      req_err   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      sb_stb    <= stb_nxt;
      sb_rw     <= rw_nxt;
      sb_addr   <= addr_nxt;
      sb_wdata  <= wdata_nxt;
      req_rdata <= rdata_nxt;
      grant_id  <= gid_nxt;
      req_done  <= done_nxt;
      req_err   <= err_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sbus_arbiter.sv
// Directed bench for sbus_arbiter (NREQ=2, TIMEOUT=16): cycle table for the
// basic write/read/contention flows, hand sequences for timeout and reset.
module tb_sbus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_stb = '0, req_rw = 2'b01;
  logic [15:0] req_addr = {8'h0C, 8'h08};
  logic [15:0] req_wdata = {8'h77, 8'h5A};
  logic [1:0]  req_done, req_err, grant_id;
  logic [7:0]  req_rdata, sb_addr, sb_wdata;
  logic [7:0]  sb_rdata = 8'h00;
  logic        sb_ack = 1'b0;
  logic        busy, sb_stb, sb_rw;

  sbus_arbiter #(.NREQ(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_stb(req_stb), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .grant_id(grant_id), .busy(busy),
    .sb_stb(sb_stb), .sb_rw(sb_rw), .sb_addr(sb_addr), .sb_wdata(sb_wdata),
    .sb_rdata(sb_rdata), .sb_ack(sb_ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  stb;
    logic        ack;
    logic [7:0]  rd;
    logic [32:0] exp;
  } vec_t;
  vec_t tbl[$];

  logic [32:0] act;
  assign act = {sb_stb, sb_rw, sb_addr, sb_wdata, req_done, req_err, req_rdata, grant_id, busy};

  function automatic logic [32:0] ex(logic s, logic rw, logic [7:0] a, logic [7:0] w,
                                     logic [1:0] d, logic [1:0] e, logic [7:0] rd,
                                     logic [1:0] g, logic b);
    return {s, rw, a, w, d, e, rd, g, b};
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic add(input logic [1:0] s, input logic a, input logic [7:0] r, input logic [32:0] e);
    vec_t v;
    v.stb = s; v.ack = a; v.rd = r; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] cur;
    logic [1:0] g;
    logic       rw;
    logic [7:0] a, w, rdv;
    int         hi, k;

    // ---- reset ----
    tick; tick;
    check("reset_low", act, 33'd0);
    rst = 1'b1;
    tick;
    check("reset_released_idle", act, 33'd0);

    // ---- test 1: single write from m0, ack on 2nd strobe cycle ----
    add(2'b01, 1'b0, 8'h00, ex(1'b1, 1'b1, 8'h08, 8'h5A, 2'b00, 2'b00, 8'h00, 2'd0, 1'b1));
    add(2'b01, 1'b0, 8'h00, ex(1'b1, 1'b1, 8'h08, 8'h5A, 2'b00, 2'b00, 8'h00, 2'd0, 1'b1));
    add(2'b01, 1'b1, 8'hFF, ex(1'b0, 1'b1, 8'h08, 8'h5A, 2'b01, 2'b00, 8'h00, 2'd0, 1'b1));
    add(2'b01, 1'b0, 8'h00, ex(1'b0, 1'b1, 8'h08, 8'h5A, 2'b00, 2'b00, 8'h00, 2'd0, 1'b0));
    // ---- test 2: read from m1, then a stray ack in IDLE ----
    add(2'b10, 1'b0, 8'h00, ex(1'b1, 1'b0, 8'h0C, 8'h77, 2'b00, 2'b00, 8'h00, 2'd1, 1'b1));
    add(2'b10, 1'b1, 8'hA3, ex(1'b0, 1'b0, 8'h0C, 8'h77, 2'b10, 2'b00, 8'hA3, 2'd1, 1'b1));
    add(2'b10, 1'b0, 8'h00, ex(1'b0, 1'b0, 8'h0C, 8'h77, 2'b00, 2'b00, 8'hA3, 2'd1, 1'b0));
    add(2'b00, 1'b1, 8'h11, ex(1'b0, 1'b0, 8'h0C, 8'h77, 2'b00, 2'b00, 8'hA3, 2'd1, 1'b0));
    // ---- test 3: both masters always requesting, 4 rounds alternate 0,1,0,1 ----
    cur = 8'hA3;
    for (int r = 0; r < 4; r++) begin
      g   = {1'b0, r[0]};
      rw  = ~r[0];
      a   = r[0] ? 8'h0C : 8'h08;
      w   = r[0] ? 8'h77 : 8'h5A;
      rdv = 8'hC0 + 8'(r);
      add(2'b11, 1'b0, 8'h00, ex(1'b1, rw, a, w, 2'b00, 2'b00, cur, g, 1'b1));
      if (r[0]) cur = rdv;
      add(2'b11, 1'b1, rdv, ex(1'b0, rw, a, w, 2'b01 << g, 2'b00, cur, g, 1'b1));
      add(2'b11, 1'b0, 8'h00, ex(1'b0, rw, a, w, 2'b00, 2'b00, cur, g, 1'b0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      req_stb  = tbl[i].stb;
      sb_ack   = tbl[i].ack;
      sb_rdata = tbl[i].rd;
      tick;
      check($sformatf("vec%0d", i), act, tbl[i].exp);
    end
    req_stb = 2'b00; sb_ack = 1'b0; sb_rdata = 8'h00;

    // ---- test 4: timeout, ack never arrives ----
    req_stb = 2'b01;
    tick;
    check("to_grant", {31'd0, sb_stb, grant_id == 2'd0}, 33'b11);
    hi = 1; k = 0;
    while (sb_stb && k < 40) begin
      tick;
      k++;
      if (sb_stb) hi++;
    end
    check("to_stb_cycles", 33'(hi), 33'd16);
    check("to_done_err", {23'd0, req_done, req_err, sb_stb, busy},
          {23'd0, 2'b01, 2'b01, 1'b0, 1'b1});
    check("to_rdata_hold", 33'(req_rdata), 33'(8'hC3));
    req_stb = 2'b00;
    tick;
    check("to_pulse_end", {29'd0, req_done, req_err}, 33'd0);
    // next request served; m1 drops req_stb mid-transfer
    req_stb = 2'b10;
    tick;
    check("after_to_grant", {23'd0, sb_stb, grant_id, sb_addr}, {23'd0, 1'b1, 2'd1, 8'h0C});
    req_stb = 2'b00;
    tick;
    sb_ack = 1'b1; sb_rdata = 8'h6E;
    tick;
    check("drop_mid_xfer", {21'd0, req_done, req_err, req_rdata}, {21'd0, 2'b10, 2'b00, 8'h6E});
    sb_ack = 1'b0;
    tick;

    // ---- test 5: ack on the same cycle the timeout would fire ----
    req_stb = 2'b10;
    tick;
    check("race_grant", {31'd0, sb_stb, grant_id == 2'd1}, 33'b11);
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (sb_stb) hi++;
    end
    check("race_stb_cycles", 33'(hi), 33'd15);
    sb_ack = 1'b1; sb_rdata = 8'hB7;
    tick;
    check("race_ack_wins", {20'd0, sb_stb, req_done, req_err, req_rdata},
          {20'd0, 1'b0, 2'b10, 2'b00, 8'hB7});
    sb_ack = 1'b0; req_stb = 2'b00;
    tick;

    // ---- test 6: reset during XFER ----
    req_stb = 2'b01;
    tick;
    check("rst_grant_m0", {31'd0, sb_stb, grant_id == 2'd0}, 33'b11);
    tick;
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_drop", {29'd0, sb_stb, req_done, busy}, 33'd0);
    req_stb = 2'b11;
    tick; tick;
    rst = 1'b1;
    check("rst_no_done", {31'd0, req_done}, 33'd0);
    tick;
    check("rst_m0_first", {22'd0, sb_stb, grant_id, sb_addr}, {22'd0, 1'b1, 2'd0, 8'h08});
    sb_ack = 1'b1;
    tick;
    check("rst_then_done", {31'd0, req_done}, 33'(2'b01));
    sb_ack = 1'b0; req_stb = 2'b00;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
